dma_hif_sequencer: RTL and testbench
====================================

Name: dma_hif_sequencer

Overview:
- Word-granular transfer sequencer directly upstream of the AHB master interface.
- Accepts one transfer command (start address, length in words, direction) from the DMA engine.
- Drives the dmaHIF* request interface beat by beat: streams write data in, buffers returned read data in a small FIFO, and reports completion or error.
- Read issue is credit-limited so read data arriving from the AHB side is never dropped.

Parameters:
- FIFO_DEPTH, 4, read-data FIFO entries; power of two, minimum 2.
- LEN_WIDTH, 16, width of the word-count field.

Ports:
- macPIClk  in  1  platform clock.
- macPIClkHardRst  in  1  asynchronous active-high reset.
- cmdValid  in  1  command request.
- cmdReady  out  1  sequencer idle; command accepted when cmdValid&cmdReady.
- cmdAddr  in  32  start byte address; bits [1:0] ignored and forced to 00.
- cmdLen  in  LEN_WIDTH  number of 32-bit words.
- cmdWrite  in  1  1 = write to host, 0 = read from host.
- wrData  in  32  write stream data.
- wrValid  in  1  write stream valid.
- wrReady  out  1  write beat consumed.
- rdData  out  32  read stream data, FIFO head.
- rdValid  out  1  FIFO not empty.
- rdReady  in  1  read stream pop.
- dmaHIFRead  out  1  read request.
- dmaHIFWrite  out  1  write request.
- dmaHIFAddressIn  out  32  beat address.
- dmaHIFSize  out  3  constant 3'b010 (word).
- dmaHIFWriteDataIn  out  32  equal to wrData.
- dmaHIFReady  in  1  current beat accepted.
- dmaHIFReadDataOut  in  32  returned read data.
- dmaHIFReadDataValid  in  1  read data strobe; cannot be back-pressured.
- dmaHIFTransComplete  in  1  burst finished pulse.
- dmaHIFError  in  1  bus error pulse.
- done  out  1  one-cycle pulse at end of command.
- doneErr  out  1  qualifies done; 1 = command aborted on error.

Behaviour:
- Interface: one clock (macPIClk); reset is asynchronous and active-high (macPIClkHardRst).
- Reset values:
  - All outputs 0, except cmdReady = 1 and dmaHIFSize = 3'b010.
  - FIFO empty; all counters 0; state IDLE.
- IDLE:
  - cmdReady = 1.
  - On accept, latch addr (word-aligned), remaining = cmdLen, dir.
  - cmdLen = 0: next cycle pulse done (doneErr = 0); stay IDLE.
  - Otherwise go to ISSUE.
- ISSUE:
  - dmaHIFAddressIn = current addr.
  - Write: dmaHIFWrite = wrValid && remaining != 0. wrReady = dmaHIFWrite && dmaHIFReady (combinational).
  - Read: dmaHIFRead = (remaining != 0) && (fifoCount + outstanding < FIFO_DEPTH).
  - Beat accepted = request && dmaHIFReady. On accept: addr += 4 (32-bit wrap, no saturation); remaining -= 1; for reads, outstanding += 1.
  - After the last beat is accepted the request deasserts in the same cycle; go to DRAIN.
- DRAIN: wait for dmaHIFTransComplete and, for reads, outstanding == 0. Then pulse done (doneErr = 0) and go to IDLE.
- Read path:
  - dmaHIFReadDataValid pushes dmaHIFReadDataOut into the FIFO and decrements outstanding.
  - Credit rule guarantees the FIFO is never written while full. A push while full is a design error; assert it in simulation.
  - Pop when rdValid && rdReady. Simultaneous push and pop keeps the count unchanged.
  - Read data is valid on rdData 1 cycle after the strobe.
  - Pop while empty is ignored.
- Error: dmaHIFError in ISSUE or DRAIN:
  - Requests drop next cycle.
  - FIFO flushed; outstanding cleared.
  - done and doneErr pulse together; go to IDLE.
  - dmaHIFError in IDLE is ignored.
- dmaHIFTransComplete in ISSUE (boundary split only) does not end the command.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Latency: first request asserted the cycle after command accept.

Optional Feature:
- Macro: RW_HIF_SEQ_1KB_SPLIT_EN.
- With the macro: when the next beat address crosses a 1 KB boundary (addr[9:0] wraps to 0) and remaining != 0:
  - Deassert the request.
  - Wait for dmaHIFTransComplete, and outstanding == 0 for reads.
  - Resume in ISSUE the following cycle.
  - No AHB burst ever spans a 1 KB boundary.
- Without the macro: a single continuous request for the whole command; only one dmaHIFTransComplete is expected, in DRAIN.

Test Plan:
- Write, addr 0x1000_0000, len 4, wrValid always 1, dmaHIFReady always 1:
  - Addresses 0x1000_0000/04/08/0C on consecutive cycles; 4 wrReady pulses.
  - TransComplete 2 cycles later -> done = 1, doneErr = 0.
- Read, len 8, FIFO_DEPTH 4, rdReady = 0:
  - Exactly 4 beats issued, then dmaHIFRead = 0.
  - After 2 pops, 2 more beats issued; no overflow.
  - Final 8 words returned in order; done after the last pop is not required, only after outstanding reaches 0 and TransComplete.
- cmdLen = 0 -> no dmaHIF activity; done pulse on the next cycle; cmdReady stays 1.
- Read len 6, dmaHIFError after 3 beats:
  - dmaHIFRead = 0 the next cycle; rdValid = 0.
  - done = doneErr = 1 for one cycle; a new command is accepted afterwards.
- Macro on, write from 0x0000_03F8, len 4:
  - Request drops after 0x3FC.
  - Resumes at 0x400 only after TransComplete.
  - Two TransComplete pulses; one done.
- Reset asserted mid-read with 2 words in the FIFO -> rdValid = 0 and cmdReady = 1 immediately; no done pulse.

Source files
------------

// File: rtl/dma_hif_sequencer.sv
// Word-granular DMA transfer sequencer in front of the AHB master (dmaHIF* request interface).
// Optional RW_HIF_SEQ_1KB_SPLIT_EN: pause the request at every 1 KB boundary until the burst completes.
module dma_hif_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 macPIClk,
  input  logic                 macPIClkHardRst,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic [31:0]          cmdAddr,
  input  logic [LEN_WIDTH-1:0] cmdLen,
  input  logic                 cmdWrite,
  input  logic [31:0]          wrData,
  input  logic                 wrValid,
  output logic                 wrReady,
  output logic [31:0]          rdData,
  output logic                 rdValid,
  input  logic                 rdReady,
  output logic                 dmaHIFRead,
  output logic                 dmaHIFWrite,
  output logic [31:0]          dmaHIFAddressIn,
  output logic [2:0]           dmaHIFSize,
  output logic [31:0]          dmaHIFWriteDataIn,
  input  logic                 dmaHIFReady,
  input  logic [31:0]          dmaHIFReadDataOut,
  input  logic                 dmaHIFReadDataValid,
  input  logic                 dmaHIFTransComplete,
  input  logic                 dmaHIFError,
  output logic                 done,
  output logic                 doneErr
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_SPLIT} state_e;
  state_e state_q, state_d;

  logic [31:0]          addr_q, addr_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 dir_wr_q, dir_wr_d;
  logic [CW-1:0]        outst_q, outst_d;
  logic                 tc_seen_q, tc_seen_d;
  logic                 done_q, done_d;
  logic                 done_err_q, done_err_d;

  logic [31:0]          mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        cnt_q;

  logic                 req_wr, req_rd, beat_acc, push, pop, flush;
  logic [CW:0]          credit_used;

  assign credit_used = {1'b0, cnt_q} + {1'b0, outst_q};
  assign beat_acc    = (req_wr | req_rd) & dmaHIFReady;
  // Late read strobes after an abort have nowhere to go; only accept data while a command is live.
  assign push        = dmaHIFReadDataValid & (state_q != S_IDLE);
  assign pop         = rdReady & (cnt_q != '0);
  assign flush       = dmaHIFError & (state_q != S_IDLE);

  always_ff @(posedge macPIClk or posedge macPIClkHardRst) begin
    if (macPIClkHardRst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      dir_wr_q   <= 1'b0;
      outst_q    <= '0;
      tc_seen_q  <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      dir_wr_q   <= dir_wr_d;
      outst_q    <= outst_d;
      tc_seen_q  <= tc_seen_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    dir_wr_d   = dir_wr_q;
    tc_seen_d  = tc_seen_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    outst_d    = outst_q;
    if (req_rd && dmaHIFReady) outst_d = outst_d + CW'(1);
    if (push)                  outst_d = outst_d - CW'(1);
    unique case (state_q)
      S_IDLE: begin
        if (cmdValid) begin
          if (cmdLen == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d   = cmdAddr & ~32'h3;
            rem_d    = cmdLen;
            dir_wr_d = cmdWrite;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (beat_acc) begin
          addr_d = addr_q + 32'd4;
          rem_d  = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
`ifdef RW_HIF_SEQ_1KB_SPLIT_EN
          else if (addr_d[9:0] == '0) state_d = S_SPLIT;
`endif
        end
      end
      S_DRAIN, S_SPLIT: begin
        // Completion may precede the last read strobe, so remember it until credits return.
        tc_seen_d = tc_seen_q | dmaHIFTransComplete;
        if (tc_seen_d && (dir_wr_q || outst_q == '0)) begin
          tc_seen_d = 1'b0;
          if (state_q == S_DRAIN) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d    = S_IDLE;
      tc_seen_d  = 1'b0;
      outst_d    = '0;
      done_d     = 1'b1;
      done_err_d = 1'b1;
    end
  end

  always_comb begin
    cmdReady = (state_q == S_IDLE);
    req_wr   = 1'b0;
    req_rd   = 1'b0;
    if (state_q == S_ISSUE && rem_q != '0) begin
      if (dir_wr_q) req_wr = wrValid;
      else          req_rd = (credit_used < DEPTH_L);
    end
  end

  always_ff @(posedge macPIClk or posedge macPIClkHardRst) begin
    if (macPIClkHardRst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= dmaHIFReadDataOut;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  fifo_no_overflow: assert property (@(posedge macPIClk) disable iff (macPIClkHardRst)
    !(push && cnt_q == CW'(FIFO_DEPTH)));

  assign wrReady           = req_wr & dmaHIFReady;
  assign dmaHIFWrite       = req_wr;
  assign dmaHIFRead        = req_rd;
  assign dmaHIFAddressIn   = addr_q;
  assign dmaHIFSize        = 3'b010;
  assign dmaHIFWriteDataIn = wrData;
  assign rdData            = mem_q[rptr_q];
  assign rdValid           = (cnt_q != '0);
  assign done              = done_q;
  assign doneErr           = done_err_q;
endmodule

// File: tb/tb_dma_hif_sequencer.sv
// Self-checking bench for dma_hif_sequencer: transaction-level model plus directed scenarios and random traffic.
module tb_dma_hif_sequencer;
  localparam int DEPTH = 4;
  localparam int LW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmdValid, cmdReady, cmdWrite;
  logic [31:0]   cmdAddr;
  logic [LW-1:0] cmdLen;
  logic [31:0]   wrData, rdData, dmaHIFAddressIn, dmaHIFWriteDataIn, dmaHIFReadDataOut;
  logic          wrValid, wrReady, rdValid, rdReady;
  logic          dmaHIFRead, dmaHIFWrite, dmaHIFReady;
  logic [2:0]    dmaHIFSize;
  logic          dmaHIFReadDataValid, dmaHIFTransComplete, dmaHIFError;
  logic          done, doneErr;

  always #5 clk = ~clk;

  dma_hif_sequencer #(.FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .macPIClk(clk), .macPIClkHardRst(rst),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdAddr(cmdAddr), .cmdLen(cmdLen), .cmdWrite(cmdWrite),
    .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
    .rdData(rdData), .rdValid(rdValid), .rdReady(rdReady),
    .dmaHIFRead(dmaHIFRead), .dmaHIFWrite(dmaHIFWrite), .dmaHIFAddressIn(dmaHIFAddressIn),
    .dmaHIFSize(dmaHIFSize), .dmaHIFWriteDataIn(dmaHIFWriteDataIn), .dmaHIFReady(dmaHIFReady),
    .dmaHIFReadDataOut(dmaHIFReadDataOut), .dmaHIFReadDataValid(dmaHIFReadDataValid),
    .dmaHIFTransComplete(dmaHIFTransComplete), .dmaHIFError(dmaHIFError),
    .done(done), .doneErr(doneErr)
  );

  int tests, fails;

  // Model: a command is "busy" from accept to done; "waiting" means the request is paused for a completion.
  bit          m_busy, m_wait, m_tcseen, m_dirw, m_done, m_doneerr;
  logic [31:0] m_addr;
  int          m_left, m_infl;
  logic [31:0] m_q[$];

  int          obs_wr, obs_rd, obs_done, obs_err;
  logic [31:0] obs_addr[$];
  logic [31:0] obs_pop[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_tcseen = 0; m_dirw = 0; m_done = 0; m_doneerr = 0;
    m_addr = '0; m_left = 0; m_infl = 0; m_q.delete();
  endtask

  task automatic clear_obs();
    obs_wr = 0; obs_rd = 0; obs_done = 0; obs_err = 0;
    obs_addr.delete(); obs_pop.delete();
  endtask

  task automatic set_idle();
    cmdValid = 0; cmdAddr = '0; cmdLen = '0; cmdWrite = 0;
    wrData = $urandom; wrValid = 0; rdReady = 0; dmaHIFReady = 0;
    dmaHIFReadDataOut = '0; dmaHIFReadDataValid = 0; dmaHIFTransComplete = 0; dmaHIFError = 0;
  endtask

  // Called at a negedge with inputs applied; checks all outputs, advances the model, returns at next negedge.
  task automatic cycle();
    bit ereq, ew, er, acc;
    int qs, infl0;
    #1;
    qs    = m_q.size();
    ereq  = m_busy && !m_wait && m_left > 0;
    ew    = ereq && m_dirw && wrValid;
    er    = ereq && !m_dirw && (qs + m_infl < DEPTH);
    acc   = (ew || er) && dmaHIFReady;
    chk("cmdReady", cmdReady, !m_busy);
    chk("dmaHIFWrite", dmaHIFWrite, ew);
    chk("dmaHIFRead", dmaHIFRead, er);
    chk("wrReady", wrReady, ew && dmaHIFReady);
    if (ew || er) chk("dmaHIFAddressIn", dmaHIFAddressIn, m_addr);
    chk("dmaHIFSize", dmaHIFSize, 3'b010);
    chk("dmaHIFWriteDataIn", dmaHIFWriteDataIn, wrData);
    chk("rdValid", rdValid, qs != 0);
    if (qs != 0) chk("rdData", rdData, m_q[0]);
    chk("done", done, m_done);
    chk("doneErr", doneErr, m_doneerr);

    if (ew && dmaHIFReady) begin obs_wr++; obs_addr.push_back(dmaHIFAddressIn); end
    if (er && dmaHIFReady) obs_rd++;
    if (done) obs_done++;
    if (done && doneErr) obs_err++;
    if (rdValid && rdReady) obs_pop.push_back(rdData);

    m_done = 0; m_doneerr = 0;
    infl0 = m_infl;
    if (!m_busy) begin
      if (qs != 0 && rdReady) void'(m_q.pop_front());
      if (cmdValid) begin
        if (cmdLen == 0) m_done = 1;
        else begin
          m_busy = 1; m_wait = 0; m_tcseen = 0;
          m_addr = {cmdAddr[31:2], 2'b00}; m_left = int'(cmdLen); m_dirw = cmdWrite;
        end
      end
    end else if (dmaHIFError) begin
      m_busy = 0; m_wait = 0; m_q.delete(); m_infl = 0; m_done = 1; m_doneerr = 1;
    end else begin
      if (qs != 0 && rdReady) void'(m_q.pop_front());
      if (dmaHIFReadDataValid) begin m_q.push_back(dmaHIFReadDataOut); m_infl--; end
      if (m_wait) begin
        if (dmaHIFTransComplete) m_tcseen = 1;
        if (m_tcseen && (m_dirw || infl0 == 0)) begin
          if (m_left == 0) begin m_busy = 0; m_wait = 0; m_done = 1; end
          else begin m_wait = 0; m_tcseen = 0; end
        end
      end else if (acc) begin
        m_addr = m_addr + 32'd4;
        m_left--;
        if (!m_dirw) m_infl++;
        if (m_left == 0) begin m_wait = 1; m_tcseen = 0; end
`ifdef RW_HIF_SEQ_1KB_SPLIT_EN
        else if (m_addr[9:0] == 10'd0) begin m_wait = 1; m_tcseen = 0; end
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    cmdValid = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 1) == 1) cmdAddr = $urandom;
    else cmdAddr = 32'h400 * $urandom_range(0, 8) - 32'd4 * $urandom_range(0, 6);
    cmdLen   = ($urandom_range(0, 7) == 0) ? LW'(0) : LW'($urandom_range(1, 12));
    cmdWrite = $urandom_range(0, 1);
    wrValid  = ($urandom_range(0, 3) != 0);
    wrData   = $urandom;
    rdReady  = ($urandom_range(0, 2) != 0);
    dmaHIFReady         = ($urandom_range(0, 3) != 0);
    dmaHIFReadDataValid = m_busy && (m_infl > 0) && ($urandom_range(0, 1) == 1);
    dmaHIFReadDataOut   = $urandom;
    dmaHIFTransComplete = m_busy && (m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0));
    dmaHIFError         = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    tests = 0; fails = 0;
    set_idle(); model_reset(); clear_obs();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmdReady", cmdReady, 1);
    chk("rst_size", dmaHIFSize, 3'b010);
    chk("rst_rdValid", rdValid, 0);
    chk("rst_done", done, 0);
    chk("rst_doneErr", doneErr, 0);
    chk("rst_read", dmaHIFRead, 0);
    chk("rst_write", dmaHIFWrite, 0);
    chk("rst_addr", dmaHIFAddressIn, 0);
    chk("rst_rdData", rdData, 0);
    @(negedge clk);
    rst = 0;

    // Write of four words with continuous data and ready.
    clear_obs(); set_idle();
    cmdValid = 1; cmdAddr = 32'h1000_0000; cmdLen = LW'(4); cmdWrite = 1; wrValid = 1; dmaHIFReady = 1;
    cycle(); cmdValid = 0;
    repeat (4) begin wrData = $urandom; cycle(); end
    cycle();
    dmaHIFTransComplete = 1; cycle(); dmaHIFTransComplete = 0;
    cycle();
    chk("wr_beats", obs_wr, 4);
    if (obs_addr.size() == 4) begin
      chk("wr_addr0", obs_addr[0], 32'h1000_0000);
      chk("wr_addr1", obs_addr[1], 32'h1000_0004);
      chk("wr_addr2", obs_addr[2], 32'h1000_0008);
      chk("wr_addr3", obs_addr[3], 32'h1000_000C);
    end
    chk("wr_done", obs_done, 1);
    chk("wr_doneErr", obs_err, 0);

    // Zero-length command completes on the next cycle with no bus activity.
    clear_obs(); set_idle();
    cmdValid = 1; cmdAddr = 32'h5555_0000; cmdLen = '0; cmdWrite = 1; wrValid = 1; dmaHIFReady = 1;
    cycle(); cmdValid = 0;
    cycle();
    chk("len0_done", obs_done, 1);
    chk("len0_doneErr", obs_err, 0);
    chk("len0_beats", obs_wr + obs_rd, 0);

    // Read of eight words with the consumer stalled: credit limits issue to the FIFO depth.
    clear_obs(); set_idle();
    cmdValid = 1; cmdAddr = 32'h2000_0002; cmdLen = LW'(8); cmdWrite = 0; dmaHIFReady = 1;
    cycle(); cmdValid = 0;
    repeat (6) cycle();
    chk("rd_credit_stall", obs_rd, 4);
    for (int k = 0; k < 4; k++) begin
      dmaHIFReadDataValid = 1; dmaHIFReadDataOut = 32'hA0 + 32'(k); cycle();
    end
    dmaHIFReadDataValid = 0;
    chk("rd_full_no_issue", obs_rd, 4);
    rdReady = 1; repeat (2) cycle(); rdReady = 0;
    repeat (3) cycle();
    chk("rd_after_pop", obs_rd, 6);
    nxt = 4;
    for (int k = 0; k < 60 && obs_done == 0; k++) begin
      rdReady = 1;
      dmaHIFReadDataValid = (m_infl > 0);
      if (m_infl > 0) begin dmaHIFReadDataOut = 32'hA0 + 32'(nxt); nxt++; end
      dmaHIFTransComplete = m_wait;
      cycle();
    end
    set_idle(); rdReady = 1;
    repeat (5) cycle();
    chk("rd_beats", obs_rd, 8);
    chk("rd_done", obs_done, 1);
    chk("rd_doneErr", obs_err, 0);
    chk("rd_pop_count", obs_pop.size(), 8);
    if (obs_pop.size() == 8)
      for (int k = 0; k < 8; k++) chk("rd_order", obs_pop[k], 32'hA0 + 32'(k));

    // Bus error after three read beats aborts and flushes.
    clear_obs(); set_idle();
    cmdValid = 1; cmdAddr = 32'h3000_0000; cmdLen = LW'(6); cmdWrite = 0; dmaHIFReady = 1;
    cycle(); cmdValid = 0;
    for (int k = 0; k < 3; k++) begin
      dmaHIFReadDataValid = (k > 0); dmaHIFReadDataOut = 32'hB0 + 32'(k); cycle();
    end
    dmaHIFReadDataValid = 0;
    chk("err_fifo_filled", rdValid, 1);
    dmaHIFReady = 0; dmaHIFError = 1; cycle(); dmaHIFError = 0;
    cycle();
    chk("err_beats", obs_rd, 3);
    chk("err_done", obs_err, 1);
    cmdValid = 1; cmdAddr = 32'h3000_0040; cmdLen = LW'(1); cmdWrite = 1; wrValid = 1; dmaHIFReady = 1;
    cycle(); cmdValid = 0;
    cycle(); wrValid = 0;
    cycle();
    dmaHIFTransComplete = 1; cycle(); dmaHIFTransComplete = 0;
    cycle();
    chk("post_err_wr", obs_wr, 1);
    chk("post_err_done", obs_done, 2);
    chk("post_err_doneErr", obs_err, 1);

`ifdef RW_HIF_SEQ_1KB_SPLIT_EN
    // Write across a 1 KB boundary pauses until the first burst completes.
    clear_obs(); set_idle();
    cmdValid = 1; cmdAddr = 32'h0000_03F8; cmdLen = LW'(4); cmdWrite = 1; wrValid = 1; dmaHIFReady = 1;
    cycle(); cmdValid = 0;
    repeat (5) cycle();
    chk("split_pause", obs_wr, 2);
    dmaHIFTransComplete = 1; cycle(); dmaHIFTransComplete = 0;
    repeat (3) cycle();
    chk("split_beats", obs_wr, 4);
    if (obs_addr.size() == 4) begin
      chk("split_addr1", obs_addr[1], 32'h0000_03FC);
      chk("split_addr2", obs_addr[2], 32'h0000_0400);
    end
    dmaHIFTransComplete = 1; cycle(); dmaHIFTransComplete = 0;
    cycle();
    chk("split_done", obs_done, 1);
`endif

    // Asynchronous reset in the middle of a read with two words buffered.
    clear_obs(); set_idle();
    cmdValid = 1; cmdAddr = 32'h4000_0000; cmdLen = LW'(8); cmdWrite = 0; dmaHIFReady = 1;
    cycle(); cmdValid = 0;
    for (int k = 0; k < 3; k++) begin
      dmaHIFReadDataValid = (k > 0); dmaHIFReadDataOut = 32'hC0 + 32'(k); cycle();
    end
    dmaHIFReadDataValid = 0;
    chk("rstmid_fifo2", m_q.size(), 2);
    rst = 1;
    #1;
    chk("rstmid_rdValid", rdValid, 0);
    chk("rstmid_cmdReady", cmdReady, 1);
    chk("rstmid_read", dmaHIFRead, 0);
    model_reset();
    @(negedge clk);
    set_idle(); rst = 0;
    repeat (3) cycle();
    chk("rstmid_no_done", obs_done, 0);

    // Random traffic against the model.
    set_idle();
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
